// File: rtl/reg_arb_pkg.sv
// Shared types and the round-robin winner function for the register-load arbiter.
package reg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      HOLD
   } arb_state_t;

   localparam int unsigned MAX_REQ = 16;

   // Scans from the highest offset down so the lowest offset from ptr wins.
   function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                          input logic [3:0]         ptr,
                                          input int unsigned        nreq);
      logic [3:0]  win;
      int unsigned off;
      int unsigned idx;
      win = '0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         off = MAX_REQ - 1 - k;
         if (off < nreq) begin
            idx = (32'(ptr) + off) % nreq;
            if (req[idx[3:0]]) win = idx[3:0];
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/rr_pick_core.sv
// Combinational round-robin priority encoder: lowest requester at or above the pointer, wrapping.
module rr_pick_core
   import reg_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] rr_ptr_i,
   output logic                    valid_o,
   output logic [$clog2(NREQ)-1:0] winner_o
);

   localparam int unsigned IW = $clog2(NREQ);

   always_comb begin
      valid_o  = |req_i;
      winner_o = IW'(rr_pick(MAX_REQ'(req_i), 4'(rr_ptr_i), NREQ));
   end

endmodule

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter sequencing single-cycle loads of a shared register, with a guard interval.
module reg_load_arbiter
   import reg_arb_pkg::*;
#(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned NREQ        = 4,
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         gnt,
   output logic                    load,
   output logic [WIDTH-1:0]        d,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    busy
);

   localparam int unsigned IW  = $clog2(NREQ);
   localparam int unsigned HCW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

   arb_state_t       state_q;
   logic [IW-1:0]    rr_ptr_q;
   logic [IW-1:0]    owner_q;
   logic [HCW-1:0]   hold_cnt_q;
   logic [NREQ-1:0]  gnt_q;
   logic             load_q;
   logic             busy_q;
   logic [WIDTH-1:0] d_q;

   logic             req_valid;
   logic [IW-1:0]    win_idx;
   logic [WIDTH-1:0] d_d;
   logic [NREQ-1:0]  gnt_d;
   logic [IW-1:0]    rr_ptr_d;

   rr_pick_core #(.NREQ(NREQ)) u_pick (
      .req_i   (req),
      .rr_ptr_i(rr_ptr_q),
      .valid_o (req_valid),
      .winner_o(win_idx)
   );

   always_comb begin
      d_d      = req_data[32'(win_idx)*WIDTH +: WIDTH];
      gnt_d    = NREQ'(1) << win_idx;
      rr_ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         hold_cnt_q <= '0;
         gnt_q      <= '0;
         load_q     <= 1'b0;
         busy_q     <= 1'b0;
         d_q        <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  state_q <= LOAD;
                  load_q  <= 1'b1;
                  gnt_q   <= gnt_d;
                  busy_q  <= 1'b1;
                  d_q     <= d_d;
                  owner_q <= win_idx;
               end
            end
            LOAD: begin
               load_q   <= 1'b0;
               gnt_q    <= '0;
               rr_ptr_q <= rr_ptr_d;
               if (HOLD_CYCLES != 0) begin
                  state_q    <= HOLD;
                  hold_cnt_q <= HCW'(HOLD_CYCLES - 1);
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            HOLD: begin
               if (hold_cnt_q == '0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  hold_cnt_q <= hold_cnt_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt   = gnt_q;
   assign load  = load_q;
   assign d     = d_q;
   assign owner = owner_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Directed bench for reg_load_arbiter, with a model of the downstream register and a HOLD_CYCLES=0 build.
module tb_reg_load_arbiter;

   localparam int unsigned W = 16;
   localparam int unsigned N = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] req = '0;
   logic [N-1:0] req0 = '0;
   logic [N*W-1:0] req_data;

   logic [N-1:0] gnt, gnt0;
   logic         load, load0;
   logic [W-1:0] d, d0;
   logic [1:0]   owner, owner0;
   logic         busy, busy0;
   logic [W-1:0] d_r;

   logic [W-1:0] dat [N] = '{16'h0C1E, 16'h5A0B, 16'hA5A5, 16'hD3D3};

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   assign req_data = {dat[3], dat[2], dat[1], dat[0]};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Shared register driven by the arbiter's load/d.
   always_ff @(posedge clk or posedge reset)
      if (reset) d_r <= '0;
      else if (load) d_r <= d;

   reg_load_arbiter #(.WIDTH(W), .NREQ(N), .HOLD_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data),
      .gnt(gnt), .load(load), .d(d), .owner(owner), .busy(busy)
   );

   reg_load_arbiter #(.WIDTH(W), .NREQ(N), .HOLD_CYCLES(0)) dut_h0 (
      .clk(clk), .reset(reset), .req(req0), .req_data(req_data),
      .gnt(gnt0), .load(load0), .d(d0), .owner(owner0), .busy(busy0)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic wait_load(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (load === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL wait_load: load stayed low for 20 cycles, required 1");
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = (busy === 1'b0);
      for (int i = 0; i < 20 && !ok; i++) begin
         step();
         ok = (busy === 1'b0);
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL wait_idle: busy stayed high for 20 cycles, required 0");
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (load !== 1'b0)  begin n_err++; $display("FAIL reset_load: got %b want 0", load); end
      n_cmp++; if (gnt !== 4'b0)   begin n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      n_cmp++; if (d !== 16'h0)    begin n_err++; $display("FAIL reset_d: got %h want 0000", d); end
      n_cmp++; if (owner !== 2'd0) begin n_err++; $display("FAIL reset_owner: got %0d want 0", owner); end
      n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_single();
      req = 4'b0100;
      step();
      n_cmp++; if (load !== 1'b1)     begin n_err++; $display("FAIL single_load: got %b want 1", load); end
      n_cmp++; if (gnt !== 4'b0100)   begin n_err++; $display("FAIL single_gnt: got %b want 0100", gnt); end
      n_cmp++; if (d !== 16'hA5A5)    begin n_err++; $display("FAIL single_d: got %h want a5a5", d); end
      n_cmp++; if (owner !== 2'd2)    begin n_err++; $display("FAIL single_owner: got %0d want 2", owner); end
      n_cmp++; if (busy !== 1'b1)     begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
      req = 4'b0000;
      step();
      n_cmp++; if (d_r !== 16'hA5A5)  begin n_err++; $display("FAIL single_d_r: got %h want a5a5", d_r); end
      n_cmp++; if (load !== 1'b0)     begin n_err++; $display("FAIL single_load_drop: got %b want 0", load); end
      n_cmp++; if (gnt !== 4'b0000)   begin n_err++; $display("FAIL single_gnt_drop: got %b want 0000", gnt); end
      n_cmp++; if (d !== 16'hA5A5)    begin n_err++; $display("FAIL single_d_hold: got %h want a5a5", d); end
   endtask

   task automatic test_wrap_skip();
      bit ok;
      wait_idle();
      req = 4'b0011;
      wait_load(ok);
      if (ok) begin
         n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL wrap_gnt0: got %b want 0001", gnt); end
         n_cmp++; if (d !== dat[0])    begin n_err++; $display("FAIL wrap_d0: got %h want %h", d, dat[0]); end
      end
      wait_load(ok);
      if (ok) begin
         n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL wrap_gnt1: got %b want 0010", gnt); end
         n_cmp++; if (owner !== 2'd1)  begin n_err++; $display("FAIL wrap_owner1: got %0d want 1", owner); end
      end
      req = 4'b0000;
   endtask

   task automatic test_withdrawal();
      bit ok;
      logic [N-1:0] seen;
      wait_idle();
      req = 4'b0001;
      wait_load(ok);
      if (ok) begin
         n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL wd_first_gnt: got %b want 0001", gnt); end
      end
      req = 4'b0000;
      step();
      req = 4'b0010;
      step();
      req = 4'b0000;
      seen = '0;
      for (int i = 0; i < 6; i++) begin
         step();
         seen = seen | gnt;
      end
      n_cmp++; if (seen !== 4'b0000) begin n_err++; $display("FAIL wd_no_gnt: got %b want 0000", seen); end
      n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL wd_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      wait_idle();
      req = 4'b0100;
      wait_load(ok);
      reset = 1'b1;
      #1;
      n_cmp++; if (load !== 1'b0)  begin n_err++; $display("FAIL rmid_load: got %b want 0", load); end
      n_cmp++; if (gnt !== 4'b0)   begin n_err++; $display("FAIL rmid_gnt: got %b want 0000", gnt); end
      n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy); end
      n_cmp++; if (d !== 16'h0)    begin n_err++; $display("FAIL rmid_d: got %h want 0000", d); end
      req = 4'b1001;
      step();
      reset = 1'b0;
      step();
      n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL rmid_first_gnt: got %b want 0001", gnt); end
      n_cmp++; if (d !== dat[0])    begin n_err++; $display("FAIL rmid_first_d: got %h want %h", d, dat[0]); end
      req = 4'b0000;
   endtask

   task automatic test_fairness();
      bit ok;
      int last;
      int k;
      req = 4'b0000;
      do_reset();
      req = 4'b1111;
      last = 0;
      for (int i = 0; i < 12; i++) begin
         wait_load(ok);
         if (!ok) break;
         k = i % 4;
         n_cmp++; if (gnt !== 4'(1 << k)) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, 4'(1 << k)); end
         n_cmp++; if (d !== dat[k])       begin n_err++; $display("FAIL rr_d[%0d]: got %h want %h", i, d, dat[k]); end
         if (i > 0) begin
            n_cmp++; if (cyc - last !== 4) begin n_err++; $display("FAIL rr_spacing[%0d]: got %0d want 4", i, cyc - last); end
         end
         last = cyc;
      end
      req = 4'b0000;
   endtask

   task automatic test_hold0();
      bit ok;
      req0 = 4'b0001;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (load0 === 1'b1) begin ok = 1'b1; break; end
      end
      n_cmp++; if (!ok) begin n_err++; $display("FAIL h0_first_load: got 0 want 1 within 10 cycles"); end
      if (ok) begin
         for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++; if (load0 !== 1'b0)   begin n_err++; $display("FAIL h0_gap[%0d]: got %b want 0", i, load0); end
            step();
            n_cmp++; if (load0 !== 1'b1)   begin n_err++; $display("FAIL h0_load[%0d]: got %b want 1", i, load0); end
            n_cmp++; if (gnt0 !== 4'b0001) begin n_err++; $display("FAIL h0_gnt[%0d]: got %b want 0001", i, gnt0); end
         end
      end
      req0 = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap_skip();
      test_withdrawal();
      test_reset_mid();
      test_fairness();
      test_hold0();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
